// File: rtl/tlb_pkg.sv
// tlb_pkg: shared constants, FSM state encoding and captured-request record
// for the TLB lookup/refill controller.
package tlb_pkg;

  localparam int ADDR_W    = 64;
  localparam int PCID_W    = 12;
  localparam int WAYS      = 8;
  localparam int WAY_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WALK_REQ,
    WALK_WAIT,
    FILL,
    RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] va;
    logic [PCID_W-1:0] pcid;
    logic              id;
  } req_t;

  // True when more than one bit of a hit vector is set.
  function automatic logic multi_hit(input logic [WAYS-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/tlb_rr_arb.sv
// tlb_rr_arb: two-port round-robin arbiter.
//   valid   - per-port request valid
//   rr_last - port granted most recently; the other port wins a tie
//   enable  - when low no grant is issued
//   grant   - one-hot grant, or zero
module tlb_rr_arb (
  input  logic [1:0] valid,
  input  logic       rr_last,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = rr_last ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: lookup/refill controller for the 8-way TLB array.
// Arbitrates the fetch (port 0) and load/store (port 1) requesters onto the
// single lookup port, walks the page table on a miss, fills a round-robin
// victim way and returns a one-cycle response. Flushes are taken in IDLE only.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   req_valid/req_ready/req_va/pcid  - per-port translation requests
//   rsp_valid/rsp_id/rsp_pa/fault    - one-cycle response pulse
//   flush_valid/all/pcid, flush_ready- flush request handshake
//   tlb_lookup_*, tlb_hit, tlb_pa    - TLB lookup port (hit 1 cycle later)
//   tlb_wr_*                         - TLB fill port
//   tlb_flush*                       - TLB flush strobe and qualifiers
//   ptw_req_*, ptw_resp_*            - page-table walker interface
//
// state     | meaning
// IDLE      | accept flush (priority) or arbitrate a request
// LOOKUP    | tlb_hit/tlb_pa valid; classify hit, multi-hit or miss
// WALK_REQ  | ptw_req_valid held until ptw_req_ready
// WALK_WAIT | waiting for walker result
// FILL      | one-cycle write into victim way
// RESP      | load response registers; rsp_valid pulses next cycle
module tlb_ctrl
  import tlb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*ADDR_W-1:0]   req_va,
  input  logic [2*PCID_W-1:0]   req_pcid,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [ADDR_W-1:0]     rsp_pa,
  output logic                  rsp_fault,
  input  logic                  flush_valid,
  input  logic                  flush_all,
  input  logic [PCID_W-1:0]     flush_pcid,
  output logic                  flush_ready,
  output logic [ADDR_W-1:0]     tlb_lookup_va,
  output logic [PCID_W-1:0]     tlb_lookup_pcid,
  input  logic [WAYS-1:0]       tlb_hit,
  input  logic [ADDR_W-1:0]     tlb_pa,
  output logic                  tlb_wr_en,
  output logic [WAYS-1:0]       tlb_wr_way,
  output logic [ADDR_W-1:0]     tlb_wr_va,
  output logic [PCID_W-1:0]     tlb_wr_pcid,
  output logic [ADDR_W-1:0]     tlb_wr_pa,
  output logic                  tlb_flush,
  output logic                  tlb_flush_all,
  output logic [PCID_W-1:0]     tlb_flush_pcid,
  output logic                  ptw_req_valid,
  input  logic                  ptw_req_ready,
  output logic [ADDR_W-1:0]     ptw_req_va,
  output logic [PCID_W-1:0]     ptw_req_pcid,
  input  logic                  ptw_resp_valid,
  input  logic [ADDR_W-1:0]     ptw_resp_pa,
  input  logic                  ptw_resp_fault
);

  state_t                 state;
  req_t                   cur;
  logic [WAY_IDX_W-1:0]   victim;
  logic                   rr_last;
  logic [ADDR_W-1:0]      res_pa;
  logic                   res_fault;
  logic [1:0]             grant;
  logic                   idle;
  logic [ADDR_W-1:0]      sel_va;
  logic [PCID_W-1:0]      sel_pcid;

  assign idle = (state == IDLE);

  tlb_rr_arb u_arb (
    .valid   (req_valid),
    .rr_last (rr_last),
    .enable  (idle && !flush_valid),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign sel_va    = grant[1] ? req_va[ADDR_W +: ADDR_W]   : req_va[0 +: ADDR_W];
  assign sel_pcid  = grant[1] ? req_pcid[PCID_W +: PCID_W] : req_pcid[0 +: PCID_W];

  // The lookup is presented in the accept cycle so tlb_hit is ready in LOOKUP.
  assign tlb_lookup_va   = idle ? ((|grant) ? sel_va   : '0) : cur.va;
  assign tlb_lookup_pcid = idle ? ((|grant) ? sel_pcid : '0) : cur.pcid;

  assign flush_ready    = idle && flush_valid;
  assign tlb_flush      = flush_ready;
  assign tlb_flush_all  = flush_ready && flush_all;
  assign tlb_flush_pcid = flush_ready ? flush_pcid : '0;

  assign ptw_req_valid = (state == WALK_REQ);
  assign ptw_req_va    = cur.va;
  assign ptw_req_pcid  = cur.pcid;

  assign tlb_wr_en   = (state == FILL);
  assign tlb_wr_way  = tlb_wr_en ? (WAYS'(1) << victim) : '0;
  assign tlb_wr_va   = cur.va;
  assign tlb_wr_pcid = cur.pcid;
  assign tlb_wr_pa   = res_pa;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      victim    <= '0;
      rr_last   <= 1'b1;
      res_pa    <= '0;
      res_fault <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_pa    <= '0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            cur     <= '{va: sel_va, pcid: sel_pcid, id: grant[1]};
            rr_last <= grant[1];
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (tlb_hit == '0) begin
            state <= WALK_REQ;
          end else if (multi_hit(tlb_hit)) begin
            res_pa    <= '0;
            res_fault <= 1'b1;
            state     <= RESP;
          end else begin
            res_pa    <= tlb_pa;
            res_fault <= 1'b0;
            state     <= RESP;
          end
        end
        WALK_REQ: begin
          if (ptw_req_ready) state <= WALK_WAIT;
        end
        WALK_WAIT: begin
          if (ptw_resp_valid) begin
            if (ptw_resp_fault) begin
              res_pa    <= '0;
              res_fault <= 1'b1;
              state     <= RESP;
            end else begin
              res_pa    <= ptw_resp_pa;
              res_fault <= 1'b0;
              state     <= FILL;
            end
          end
        end
        FILL: begin
          victim <= victim + 1'b1;
          state  <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur.id;
          rsp_pa    <= res_pa;
          rsp_fault <= res_fault;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: scoreboard bench for tlb_ctrl with a TLB model and a walker model.
module tb_tlb_ctrl;

  localparam int AW    = 64;
  localparam int PW    = 12;
  localparam int OUT_W = 386;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [2*AW-1:0] req_va = '0;
  logic [2*PW-1:0] req_pcid = '0;
  logic            rsp_valid, rsp_id, rsp_fault;
  logic [AW-1:0]   rsp_pa;
  logic            flush_valid = 1'b0, flush_all = 1'b0;
  logic [PW-1:0]   flush_pcid = '0;
  logic            flush_ready;
  logic [AW-1:0]   tlb_lookup_va;
  logic [PW-1:0]   tlb_lookup_pcid;
  logic [7:0]      tlb_hit;
  logic [AW-1:0]   tlb_pa;
  logic            tlb_wr_en;
  logic [7:0]      tlb_wr_way;
  logic [AW-1:0]   tlb_wr_va, tlb_wr_pa;
  logic [PW-1:0]   tlb_wr_pcid;
  logic            tlb_flush, tlb_flush_all;
  logic [PW-1:0]   tlb_flush_pcid;
  logic            ptw_req_valid, ptw_req_ready;
  logic [AW-1:0]   ptw_req_va;
  logic [PW-1:0]   ptw_req_pcid;
  logic            ptw_resp_valid, ptw_resp_fault;
  logic [AW-1:0]   ptw_resp_pa;
  logic [OUT_W-1:0] all_out;

  tlb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_pcid(req_pcid),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_pa(rsp_pa), .rsp_fault(rsp_fault),
    .flush_valid(flush_valid), .flush_all(flush_all), .flush_pcid(flush_pcid),
    .flush_ready(flush_ready),
    .tlb_lookup_va(tlb_lookup_va), .tlb_lookup_pcid(tlb_lookup_pcid),
    .tlb_hit(tlb_hit), .tlb_pa(tlb_pa),
    .tlb_wr_en(tlb_wr_en), .tlb_wr_way(tlb_wr_way), .tlb_wr_va(tlb_wr_va),
    .tlb_wr_pcid(tlb_wr_pcid), .tlb_wr_pa(tlb_wr_pa),
    .tlb_flush(tlb_flush), .tlb_flush_all(tlb_flush_all), .tlb_flush_pcid(tlb_flush_pcid),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
    .ptw_req_va(ptw_req_va), .ptw_req_pcid(ptw_req_pcid),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_pa(ptw_resp_pa), .ptw_resp_fault(ptw_resp_fault)
  );

  assign all_out = {req_ready, rsp_valid, rsp_id, rsp_pa, rsp_fault, flush_ready,
                    tlb_lookup_va, tlb_lookup_pcid, tlb_wr_en, tlb_wr_way, tlb_wr_va,
                    tlb_wr_pcid, tlb_wr_pa, tlb_flush, tlb_flush_all, tlb_flush_pcid,
                    ptw_req_valid, ptw_req_va, ptw_req_pcid};

  always #5 clk = ~clk;

  typedef struct { logic id; logic [AW-1:0] pa; logic fault; } rsp_exp_t;
  typedef struct { logic [7:0] way; logic [AW-1:0] va; logic [AW-1:0] pa; } fill_exp_t;

  rsp_exp_t  sb_q[$];
  fill_exp_t fill_q[$];
  rsp_exp_t  mon_r;
  fill_exp_t mon_f;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rsp_cnt = 0, wr_cnt = 0, ptw_cyc_cnt = 0, last_rsp_cyc = 0;
  logic [7:0]    cfg_hit = 8'h00;
  logic [AW-1:0] cfg_tlb_pa = '0;
  int            cfg_ready_dly = 0, cfg_resp_dly = 0;
  logic [AW-1:0] cfg_walk_pa = '0;
  logic          cfg_walk_fault = 1'b0;
  logic          exp_rr = 1'b1;
  int            exp_victim = 0;

  always @(posedge clk) cyc++;

  // TLB model: result for the address presented in one cycle appears in the next.
  initial begin : tlb_model
    logic [AW-1:0] lv;
    lv = '0; tlb_hit = '0; tlb_pa = '0;
    forever begin
      @(negedge clk);
      tlb_hit = cfg_hit;
      tlb_pa  = cfg_tlb_pa + lv;
      #3;
      lv = tlb_lookup_va;
    end
  end

  // Walker model: ready after cfg_ready_dly cycles, result cfg_resp_dly cycles later.
  initial begin : walker_model
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_pa = '0; ptw_resp_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (ptw_req_valid) begin
        repeat (cfg_ready_dly) @(negedge clk);
        ptw_req_ready = 1'b1;
        @(negedge clk);
        ptw_req_ready = 1'b0;
        repeat (cfg_resp_dly) @(negedge clk);
        ptw_resp_valid = 1'b1; ptw_resp_pa = cfg_walk_pa; ptw_resp_fault = cfg_walk_fault;
        @(negedge clk);
        ptw_resp_valid = 1'b0; ptw_resp_fault = 1'b0;
      end
    end
  end

  // Scoreboard monitor for responses and fills.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ptw_req_valid) ptw_cyc_cnt++;
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected: got id=%0d pa=%h fault=%0d, required no response",
                   rsp_id, rsp_pa, rsp_fault);
        end else begin
          mon_r = sb_q.pop_front();
          if ({rsp_id, rsp_pa, rsp_fault} !== {mon_r.id, mon_r.pa, mon_r.fault}) begin
            n_bad++;
            $display("FAIL rsp_data: got id=%0d pa=%h fault=%0d, required id=%0d pa=%h fault=%0d",
                     rsp_id, rsp_pa, rsp_fault, mon_r.id, mon_r.pa, mon_r.fault);
          end
        end
      end
      if (tlb_wr_en) begin
        wr_cnt++;
        n_cmp++;
        if (fill_q.size() == 0) begin
          n_bad++;
          $display("FAIL fill_unexpected: got way=%h pa=%h, required no fill", tlb_wr_way, tlb_wr_pa);
        end else begin
          mon_f = fill_q.pop_front();
          if ({tlb_wr_way, tlb_wr_va, tlb_wr_pa} !== {mon_f.way, mon_f.va, mon_f.pa}) begin
            n_bad++;
            $display("FAIL fill_data: got way=%h va=%h pa=%h, required way=%h va=%h pa=%h",
                     tlb_wr_way, tlb_wr_va, tlb_wr_pa, mon_f.way, mon_f.va, mon_f.pa);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    req_valid = '0; flush_valid = 1'b0;
    #2 rst_n = 1'b0;
    sb_q.delete(); fill_q.delete();
    exp_rr = 1'b1; exp_victim = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input int p, input logic [AW-1:0] va, input logic [PW-1:0] pcid,
                      input rsp_exp_t e, output int acc);
    int  n;
    bit  got;
    logic [1:0] expg;
    n = 0; got = 0; acc = -1;
    expg = 2'b01 << p;
    @(negedge clk);
    req_va[p*AW +: AW] = va; req_pcid[p*PW +: PW] = pcid; req_valid[p] = 1'b1;
    while (!got && n < 50) begin
      #1;
      if (req_ready != 2'b00) got = 1;
      else begin @(negedge clk); n++; end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL accept_timeout: req_ready=%b, required %b", req_ready, expg);
    end else begin
      if (req_ready !== expg) begin
        n_bad++;
        $display("FAIL accept_grant: req_ready=%b, required %b", req_ready, expg);
      end
      sb_q.push_back(e);
      acc = cyc + 1;
      exp_rr = p[0];
    end
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
    n_cmp++;
    if (rsp_cnt < target) begin
      n_bad++;
      $display("FAIL rsp_timeout: got %0d responses, required %0d", rsp_cnt, target);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL idle_outputs: got %h, required 0", all_out);
    end
  endtask

  task automatic test_hit();
    int acc, r0, p0;
    cfg_hit = 8'h04; cfg_tlb_pa = 64'hABB000;
    r0 = rsp_cnt; p0 = ptw_cyc_cnt;
    send(0, 64'h1000, 12'h5, '{id: 1'b0, pa: 64'hABC000, fault: 1'b0}, acc);
    wait_rsp(r0 + 1, 20);
    n_cmp++;
    if (last_rsp_cyc - acc !== 2) begin
      n_bad++; $display("FAIL hit_latency: got %0d cycles, required 2", last_rsp_cyc - acc);
    end
    n_cmp++;
    if (ptw_cyc_cnt !== p0) begin
      n_bad++; $display("FAIL hit_no_walk: got %0d walk cycles, required 0", ptw_cyc_cnt - p0);
    end
  endtask

  task automatic test_miss();
    int acc, r0, w0;
    cfg_hit = 8'h00; cfg_ready_dly = 2; cfg_resp_dly = 0;
    cfg_walk_pa = 64'h7000; cfg_walk_fault = 1'b0;
    r0 = rsp_cnt; w0 = wr_cnt;
    fill_q.push_back('{way: 8'h01 << exp_victim, va: 64'h2000, pa: 64'h7000});
    exp_victim = (exp_victim + 1) % 8;
    send(1, 64'h2000, 12'h9, '{id: 1'b1, pa: 64'h7000, fault: 1'b0}, acc);
    wait_rsp(r0 + 1, 40);
    n_cmp++;
    if (last_rsp_cyc - acc !== 7) begin
      n_bad++; $display("FAIL miss_latency: got %0d cycles, required 7", last_rsp_cyc - acc);
    end
    n_cmp++;
    if (wr_cnt - w0 !== 1) begin
      n_bad++; $display("FAIL miss_fill_count: got %0d fills, required 1", wr_cnt - w0);
    end
  endtask

  task automatic test_walk_fault();
    int acc, r0, w0;
    cfg_hit = 8'h00; cfg_ready_dly = 0; cfg_resp_dly = 1;
    cfg_walk_pa = 64'h5555000; cfg_walk_fault = 1'b1;
    r0 = rsp_cnt; w0 = wr_cnt;
    send(1, 64'h3000, 12'h9, '{id: 1'b1, pa: 64'h0, fault: 1'b1}, acc);
    wait_rsp(r0 + 1, 40);
    n_cmp++;
    if (wr_cnt !== w0) begin
      n_bad++; $display("FAIL fault_no_fill: got %0d fills, required 0", wr_cnt - w0);
    end
    cfg_walk_fault = 1'b0;
  endtask

  task automatic test_arbitration();
    int n, got, r0;
    logic g;
    logic [1:0] expg;
    n = 0; got = 0;
    cfg_hit = 8'h01; cfg_tlb_pa = 64'h100000;
    r0 = rsp_cnt;
    @(negedge clk);
    req_va = {64'hB000, 64'hA000}; req_pcid = {12'h2, 12'h1}; req_valid = 2'b11;
    while (got < 4 && n < 100) begin
      #1;
      if (req_ready != 2'b00) begin
        g = ~exp_rr;
        expg = g ? 2'b10 : 2'b01;
        n_cmp++;
        if (req_ready !== expg) begin
          n_bad++; $display("FAIL arb_grant%0d: got %b, required %b", got, req_ready, expg);
        end
        sb_q.push_back('{id: g, pa: cfg_tlb_pa + (g ? 64'hB000 : 64'hA000), fault: 1'b0});
        exp_rr = g;
        got++;
      end
      if (got < 4) begin @(negedge clk); n++; end
    end
    n_cmp++;
    if (got != 4) begin
      n_bad++; $display("FAIL arb_count: got %0d grants, required 4", got);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(r0 + got, 60);
  endtask

  task automatic test_flush();
    int r0;
    cfg_hit = 8'h06;
    r0 = rsp_cnt;
    @(negedge clk);
    flush_valid = 1'b1; flush_all = 1'b1; flush_pcid = 12'h7;
    #1;
    n_cmp++;
    if ({flush_ready, tlb_flush, tlb_flush_all} !== 3'b111) begin
      n_bad++; $display("FAIL flush_all_strobe: got %b, required 111", {flush_ready, tlb_flush, tlb_flush_all});
    end
    @(negedge clk);
    flush_all = 1'b0; flush_pcid = 12'h3;
    req_va[0 +: AW] = 64'hC000; req_pcid[0 +: PW] = 12'h3; req_valid = 2'b01;
    #1;
    n_cmp++;
    if ({flush_ready, tlb_flush, tlb_flush_all, tlb_flush_pcid, req_ready} !== {3'b110, 12'h3, 2'b00}) begin
      n_bad++;
      $display("FAIL flush_priority: got rdy=%b fl=%b all=%b pcid=%h req_ready=%b, required 1 1 0 003 00",
               flush_ready, tlb_flush, tlb_flush_all, tlb_flush_pcid, req_ready);
    end
    @(negedge clk);
    flush_valid = 1'b0;
    #1;
    n_cmp++;
    if ({tlb_flush, req_ready} !== 3'b001) begin
      n_bad++; $display("FAIL flush_then_req: got flush=%b req_ready=%b, required 0 01", tlb_flush, req_ready);
    end
    sb_q.push_back('{id: 1'b0, pa: 64'h0, fault: 1'b1});
    exp_rr = 1'b0;
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(r0 + 1, 20);
  endtask

  task automatic test_victim_wrap();
    int acc, r0;
    fill_exp_t fe;
    apply_reset();
    cfg_hit = 8'h00; cfg_ready_dly = 0; cfg_resp_dly = 0; cfg_walk_fault = 1'b0;
    r0 = rsp_cnt;
    for (int i = 0; i < 9; i++) begin
      fe.way = 8'h01 << exp_victim;
      fe.va  = 64'h10000 + 64'(i) * 64'h1000;
      fe.pa  = 64'h80000 + 64'(i);
      fill_q.push_back(fe);
      exp_victim = (exp_victim + 1) % 8;
      cfg_walk_pa = fe.pa;
      send(0, fe.va, 12'h7, '{id: 1'b0, pa: fe.pa, fault: 1'b0}, acc);
      wait_rsp(r0 + i + 1, 40);
    end
  endtask

  task automatic test_reset_mid_walk();
    int n, r0, w0, p0;
    int acc;
    cfg_hit = 8'h00; cfg_ready_dly = 0; cfg_resp_dly = 6;
    cfg_walk_pa = 64'h9999000; cfg_walk_fault = 1'b0;
    send(0, 64'h5000, 12'h1, '{id: 1'b0, pa: 64'h9999000, fault: 1'b0}, acc);
    n = 0;
    while (!ptw_req_valid && n < 20) begin @(negedge clk); #1; n++; end
    n_cmp++;
    if (!ptw_req_valid) begin
      n_bad++; $display("FAIL midwalk_req: ptw_req_valid=%b, required 1", ptw_req_valid);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL midwalk_reset_outputs: got %h, required 0", all_out);
    end
    sb_q.delete(); fill_q.delete();
    exp_rr = 1'b1; exp_victim = 0;
    @(negedge clk) rst_n = 1'b1;
    r0 = rsp_cnt; w0 = wr_cnt; p0 = ptw_cyc_cnt;
    repeat (12) @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_cnt - r0, wr_cnt - w0, ptw_cyc_cnt - p0} !== {32'd0, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL midwalk_ignored: got rsp=%0d fill=%0d walk=%0d, required 0 0 0",
               rsp_cnt - r0, wr_cnt - w0, ptw_cyc_cnt - p0);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_walk_fault();
    test_arbitration();
    test_flush();
    test_victim_wrap();
    test_reset_mid_walk();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
